// File: rtl/cpu_step_controller.sv
// Generates the one-cycle CPU clock-enable: idle, debounced single-step, divided free-run and PC breakpoint halt.
// Optional breakpoint halt is compiled in with `define CPU_STEP_BREAKPOINT_EN.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 50000000,
    parameter int PC_W            = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_step,
    input  logic            sw_run,
    input  logic [PC_W-1:0] pc_in,
    input  logic [PC_W-1:0] bp_addr,
    input  logic            bp_arm,
    output logic            cpu_en,
    output logic [15:0]     step_count,
    output logic [1:0]      state_out,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_STEP = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic            r_btn_meta, r_btn_sync, r_btn_db, r_btn_db_q;
    logic            r_sw_meta, r_sw_sync, r_sw_db;
    logic [DB_W-1:0] r_btn_cnt, r_sw_cnt;
    logic [DIV_W-1:0] r_div;
    logic [15:0]     r_step_count;
    state_t          r_state;

    logic w_step_req;
    logic w_run_lvl;
    logic w_terminal;
    logic w_bp_hit;
    logic w_cpu_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_sw_meta  <= 1'b0;
            r_sw_sync  <= 1'b0;
        end else begin
            r_btn_meta <= btn_step;
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= sw_run;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // A debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_cnt  <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
        end else begin
            r_btn_db_q <= r_btn_db;
            if (r_btn_sync == r_btn_db) begin
                r_btn_cnt <= '0;
            end else if (r_btn_cnt == DB_LAST) begin
                r_btn_db  <= r_btn_sync;
                r_btn_cnt <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_cnt <= '0;
            r_sw_db  <= 1'b0;
        end else begin
            if (r_sw_sync == r_sw_db) begin
                r_sw_cnt <= '0;
            end else if (r_sw_cnt == DB_LAST) begin
                r_sw_db  <= r_sw_sync;
                r_sw_cnt <= '0;
            end else begin
                r_sw_cnt <= r_sw_cnt + DB_W'(1);
            end
        end
    end

    assign w_step_req = r_btn_db & ~r_btn_db_q;
    assign w_run_lvl  = r_sw_db;
    assign w_terminal = (r_state == S_RUN) && (r_div == DIV_LAST);

`ifdef CPU_STEP_BREAKPOINT_EN
    assign w_bp_hit = bp_arm && (pc_in == bp_addr);
    assign halted   = (r_state == S_HALT);
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{pc_in, bp_addr, bp_arm};
    assign w_bp_hit    = 1'b0;
    assign halted      = 1'b0;
`endif

    // Enable is decoded from registered state so a reset kills it without waiting for a clock.
    assign w_cpu_en   = (r_state == S_STEP) || (w_terminal && !w_bp_hit);
    assign cpu_en     = w_cpu_en;
    assign step_count = r_step_count;
    assign state_out  = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_step_count <= '0;
        end else begin
            if (w_cpu_en) begin
                r_step_count <= r_step_count + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    if (w_run_lvl) begin
                        r_state <= S_RUN;
                    end else if (w_step_req) begin
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_state <= S_IDLE;
                end
                S_RUN: begin
                    if (!w_run_lvl) begin
                        r_state <= S_IDLE;
                        r_div   <= '0;
                    end else if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (w_bp_hit) begin
                            r_state <= S_HALT;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_HALT: begin
                    r_div <= '0;
                    if (!w_run_lvl) begin
                        r_state <= S_IDLE;
                    end else if (w_step_req) begin
                        r_state <= S_STEP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller: debounce, step, run divider, breakpoint halt, async reset, count wrap.
module tb_cpu_step_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b0;
    logic        sw = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] bp_addr = 32'h0;
    logic        bp_arm = 1'b0;
    logic        cpu_en, halted;
    logic [15:0] step_count;
    logic [1:0]  state_out;

    logic        btn1 = 1'b0;
    logic        sw1 = 1'b0;
    logic        cpu_en1, halted1;
    logic [15:0] step_count1;
    logic [1:0]  state_out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .btn_step(btn), .sw_run(sw), .pc_in(pc_in),
        .bp_addr(bp_addr), .bp_arm(bp_arm), .cpu_en(cpu_en),
        .step_count(step_count), .state_out(state_out), .halted(halted)
    );

    cpu_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1), .PC_W(32)) dut1 (
        .clk(clk), .rst(rst), .btn_step(btn1), .sw_run(sw1), .pc_in(pc_in),
        .bp_addr(bp_addr), .bp_arm(bp_arm), .cpu_en(cpu_en1),
        .step_count(step_count1), .state_out(state_out1), .halted(halted1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state0(input logic [1:0] s, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (state_out === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b expected 0", cpu_en); end
        checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state_out); end
        checks++; if (step_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0000", step_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_step_debounce();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            btn = ((i / 2) % 2 == 0);
            tick();
            if (cpu_en) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d expected 0", pulses); end
        btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (cpu_en !== (i == 7)) begin errors++; $display("FAIL step_pulse_cycle%0d: got %b expected %b", i, cpu_en, (i == 7)); end
            if (i == 8) begin
                checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL step_count: got %0d expected 1", step_count); end
                checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL step_return_idle: got %b expected 00", state_out); end
            end
        end
        btn = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cpu_en) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL release_pulses: got %0d expected 0", pulses); end
        checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL release_count: got %0d expected 1", step_count); end
    endtask

    task automatic test_run();
        bit ok;
        sw = 1'b1;
        wait_state0(2'b10, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL run_entry: got state %b expected 10", state_out); end
        for (int j = 0; j <= 46; j++) begin
            checks++;
            if (cpu_en !== (j <= 45 && j % 3 == 2)) begin
                errors++; $display("FAIL run_pulse_j%0d: got %b expected %b", j, cpu_en, (j <= 45 && j % 3 == 2));
            end
            if (j == 5) btn = 1'b1;
            if (j == 20) btn = 1'b0;
            if (j == 39) sw = 1'b0;
            if (j < 46) tick();
        end
        checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL run_exit_state: got %b expected 00", state_out); end
        checks++; if (dut.r_div !== '0) begin errors++; $display("FAIL run_exit_div: got %0d expected 0", dut.r_div); end
        checks++; if (step_count !== 16'd16) begin errors++; $display("FAIL run_count: got %0d expected 16", step_count); end
    endtask

    task automatic test_breakpoint();
        bit ok;
        bit bp_en;
        logic exp_en;
`ifdef CPU_STEP_BREAKPOINT_EN
        bp_en = 1'b1;
`else
        bp_en = 1'b0;
`endif
        bp_arm = 1'b1;
        bp_addr = 32'h0000000C;
        pc_in = 32'h0000000C;
        sw = 1'b1;
        wait_state0(2'b10, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_run_entry: got state %b expected 10", state_out); end
        for (int j = 0; j <= 15; j++) begin
            exp_en = bp_en ? (j == 10 || j == 14) : (j % 3 == 2);
            checks++;
            if (cpu_en !== exp_en) begin errors++; $display("FAIL bp_pulse_j%0d: got %b expected %b", j, cpu_en, exp_en); end
            if (j == 3) begin
                checks++; if (state_out !== (bp_en ? 2'b11 : 2'b10)) begin errors++; $display("FAIL bp_state: got %b expected %b", state_out, (bp_en ? 2'b11 : 2'b10)); end
                checks++; if (halted !== bp_en) begin errors++; $display("FAIL bp_halted: got %b expected %b", halted, bp_en); end
                checks++; if (step_count !== (bp_en ? 16'd16 : 16'd17)) begin errors++; $display("FAIL bp_count: got %0d expected %0d", step_count, (bp_en ? 16 : 17)); end
                pc_in = 32'h00000010;
                btn = 1'b1;
            end
            if (j == 11) begin
                checks++; if (state_out !== (bp_en ? 2'b00 : 2'b10)) begin errors++; $display("FAIL bp_after_step_state: got %b expected %b", state_out, (bp_en ? 2'b00 : 2'b10)); end
            end
            if (j == 12) btn = 1'b0;
            if (j < 15) tick();
        end
        checks++; if (step_count !== (bp_en ? 16'd18 : 16'd21)) begin errors++; $display("FAIL bp_final_count: got %0d expected %0d", step_count, (bp_en ? 18 : 21)); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL bp_resume_halted: got %b expected 0", halted); end
        sw = 1'b0;
        bp_arm = 1'b0;
        wait_state0(2'b00, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_exit_idle: got state %b expected 00", state_out); end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit bad;
        sw = 1'b1;
        wait_state0(2'b10, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_run_entry: got state %b expected 10", state_out); end
        tick();
        tick();
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL rst_pre_terminal: got %b expected 1", cpu_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL rst_async_cpu_en: got %b expected 0", cpu_en); end
        checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL rst_async_state: got %b expected 00", state_out); end
        checks++; if (step_count !== 16'h0) begin errors++; $display("FAIL rst_async_count: got %h expected 0000", step_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_async_halted: got %b expected 0", halted); end
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (cpu_en !== 1'b0 || state_out !== 2'b00) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rst_no_spurious: got activity expected idle"); end
        wait_state0(2'b10, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_redetect: got state %b expected 10", state_out); end
        sw = 1'b0;
        wait_state0(2'b00, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_exit_idle: got state %b expected 00", state_out); end
    endtask

    task automatic test_run_div1_wrap();
        bit ok;
        int lows;
        ok = 1'b0;
        sw1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state_out1 === 2'b10) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL div1_entry: got state %b expected 10", state_out1); end
        checks++; if (step_count1 !== 16'h0) begin errors++; $display("FAIL div1_start_count: got %h expected 0000", step_count1); end
        lows = 0;
        for (int j = 0; j <= 65536; j++) begin
            if (j < 65536 && cpu_en1 !== 1'b1) lows++;
            if (j == 65535) begin
                checks++; if (step_count1 !== 16'hFFFF) begin errors++; $display("FAIL div1_count_max: got %h expected ffff", step_count1); end
            end
            if (j < 65536) tick();
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL div1_every_cycle: got %0d idle cycles expected 0", lows); end
        checks++; if (step_count1 !== 16'h0000) begin errors++; $display("FAIL div1_wrap: got %h expected 0000", step_count1); end
        sw1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step_debounce();
        test_run();
        test_breakpoint();
        test_reset_mid_run();
        test_run_div1_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Sequences the single-cycle CPU on the Nexys A7 board by generating a one-cycle clock-enable (cpu_en) for the CPU datapath.
- Modes: idle, single-step from a debounced push button, free-run at a divided rate from a slide switch, and halt on a PC breakpoint.
- Sits between the board inputs (button/switch) and the CPU core.
- Exports step count and state so the LED/seven-segment path can display them.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a debounced input changes (10 ms at 100 MHz); minimum 1.
- RUN_DIV, 50000000, clocks per cpu_en pulse in run mode; minimum 1.
- PC_W, 32, width of program counter and breakpoint address.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- btn_step  input  1  raw step push button, asynchronous to clk.
- sw_run  input  1  raw run slide switch, asynchronous to clk.
- pc_in  input  PC_W  current CPU program counter.
- bp_addr  input  PC_W  breakpoint address.
- bp_arm  input  1  breakpoint enable.
- cpu_en  output  1  one-cycle CPU advance enable.
- step_count  output  16  number of cpu_en pulses issued.
- state_out  output  2  current FSM state encoding.
- halted  output  1  high while in HALT.

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high: when asserted, all registers clear immediately, independent of clk.
- Reset values: cpu_en=0, step_count=0, state_out=2'b00, halted=0. Synchronizers, debounce counters, debounced levels and divider all = 0.
- Input conditioning:
  - btn_step and sw_run each pass through a 2-flop synchronizer, then their own debounce counter.
  - The counter resets whenever the synced value equals the debounced value.
  - Otherwise it increments. The debounced value takes the synced value when the counter reaches DEBOUNCE_CYCLES-1.
- step_req: single-cycle pulse on a rising edge of debounced btn_step. Falling edge produces nothing.
- run_lvl: debounced sw_run level.
- FSM states: IDLE=00, STEP=01, RUN=10, HALT=11.
- IDLE:
  - run_lvl=1 → RUN.
  - else step_req=1 → STEP.
  - If both are high in the same cycle, RUN wins.
- STEP: unconditionally → IDLE next cycle.
- RUN:
  - Divider counts 0..RUN_DIV-1 and wraps to 0.
  - Terminal cycle = divider==RUN_DIV-1.
  - run_lvl=0 → IDLE, divider cleared to 0.
  - step_req is ignored in RUN.
- HALT:
  - run_lvl=0 → IDLE.
  - else step_req=1 → STEP.
  - Divider held at 0.
- cpu_en is combinational from registered state only:
  - high for exactly the one cycle in which state==STEP, or
  - in RUN on the terminal cycle (unless suppressed by the breakpoint).
  - Never high in IDLE or HALT.
- step_count increments by 1 on every cycle with cpu_en=1. Wraps 16'hFFFF→16'h0000.
- halted = (state==HALT).
- Latency: cpu_en is asserted in the cycle after the clock edge that samples step_req=1.
- Leaving HALT via step: STEP → IDLE. If run_lvl is still 1, IDLE → RUN and the divider restarts from 0.
- Reset mid-STEP or mid-RUN: any pending pulse is dropped, with no spurious cpu_en after rst deasserts. Debounced levels restart at 0, so a held button or switch is re-detected after DEBOUNCE_CYCLES.

Optional Feature:
- Macro: CPU_STEP_BREAKPOINT_EN.
- Defined:
  - In RUN on a terminal cycle with bp_arm=1 and pc_in==bp_addr: cpu_en is suppressed that cycle, step_count is unchanged, and the next state is HALT.
  - The breakpoint is checked only in RUN. Single steps always execute.
- Undefined:
  - bp_addr and bp_arm are ignored, HALT is unreachable and halted is constant 0.
  - Ports remain present so the interface is identical.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=3 unless stated):
- Assert rst mid-cycle while in RUN → cpu_en=0, state_out=00, step_count=0, halted=0 immediately, before the next clk edge.
- btn_step toggles every 2 cycles for 20 cycles, then held high 12 cycles, then released → exactly one cpu_en pulse, step_count=1, state returns to 00.
- sw_run held high 40 cycles after debounce → cpu_en high on every 3rd cycle with no gaps. A btn_step press during RUN adds no extra pulse. Drop sw_run → state 00, divider 0.
- Macro defined: bp_arm=1, bp_addr=32'h0000000C, pc_in=32'h0000000C at the first terminal cycle → no cpu_en, state_out=11, halted=1, step_count unchanged. A step press then gives one cpu_en, after which the FSM resumes RUN. With pc_in=32'h10, the next terminal cycle pulses normally.
- Macro undefined, same stimulus as the breakpoint test → cpu_en pulses normally, halted stays 0.
- RUN_DIV=1, sw_run held 65536 cycles after entering RUN → cpu_en every cycle, step_count wraps to 16'h0000.
